i2c_frame_sequencer: RTL and testbench

- Parametrised I2C write-frame sequencer; successor to the single-purpose ball-state sender.
- Latches a NUM_BYTES payload on a trigger, then drives the byte-level I2C master (start/stop/i2c_en/tx_data, ready/tx_done/nack) through ADDR, payload bytes and STOP.
- Adds NACK detection with bounded retry, abort-on-demand and status outputs.
- Sits between game logic (ball/paddle state packing) and the I2C master PHY.

---
 rtl/i2c_frame_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_i2c_frame_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_frame_sequencer.sv
// I2C write-frame sequencer: START+ADDR, NUM_BYTES payload bytes, STOP,
// with NACK retry, abort and done/error status. Optional: I2C_FRAME_CHECKSUM_EN.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   send_trigger      : rising edge (in IDLE) starts a frame
//   payload           : byte k at [8k+7:8k], byte 0 sent first
//   abort             : cancel the frame in progress
//   ready/tx_done/nack: byte-level master status
//   start/stop/i2c_en : command to the master, tx_data its byte
//   busy/done/error   : frame status, retry_cnt retries used
module i2c_frame_sequencer #(
  parameter int         NUM_BYTES = 5,
  parameter logic [7:0] SLV_ADDR  = 8'hAA,
  parameter int         MAX_RETRY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   send_trigger,
  input  logic [NUM_BYTES*8-1:0] payload,
  input  logic                   abort,
  input  logic                   ready,
  input  logic                   tx_done,
  input  logic                   nack,
  output logic                   start,
  output logic                   stop,
  output logic                   i2c_en,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             retry_cnt
);

  localparam int IW = $clog2(NUM_BYTES + 1);

`ifdef I2C_FRAME_CHECKSUM_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES);
`else
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_WAIT_ADDR,
    S_SEND,
    S_WAIT_DATA,
    S_RTY_STOP,
    S_RTY_WAIT,
    S_STOP,
    S_STOP_WAIT,
    S_ABT_HOLD,
    S_ABT_STOP,
    S_ABT_WAIT,
    S_DONE,
    S_FAIL
  } state_t;

  state_t                 state, state_n;
  logic [NUM_BYTES*8-1:0] shadow, shadow_n;
  logic [IW-1:0]          idx, idx_n, idx_inc;
  logic [7:0]             tx_n, nxt_byte;
  logic [2:0]             cnt_n;
  logic                   trig_q;
  logic                   rise, cmpl, bad;
  logic                   in_flight, abortable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      shadow    <= '0;
      idx       <= '0;
      tx_data   <= '0;
      retry_cnt <= '0;
      trig_q    <= 1'b0;
    end else begin
      state     <= state_n;
      shadow    <= shadow_n;
      idx       <= idx_n;
      tx_data   <= tx_n;
      retry_cnt <= cnt_n;
      trig_q    <= send_trigger;
    end
  end

  assign idx_inc = idx + 1'b1;

  // Byte that follows the current one; past the payload it is the checksum.
  always_comb begin
    logic [7:0] csum;
    csum     = SLV_ADDR;
    nxt_byte = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      csum = csum ^ shadow[8*k +: 8];
      if (IW'(k) == idx_inc) nxt_byte = shadow[8*k +: 8];
    end
`ifdef I2C_FRAME_CHECKSUM_EN
    if (idx_inc == IW'(NUM_BYTES)) nxt_byte = csum;
`else
    if (csum == 8'h00) nxt_byte = nxt_byte;
`endif
  end

  assign rise = send_trigger & ~trig_q;
  assign cmpl = tx_done | ready;
  assign bad  = tx_done & nack;

  assign in_flight = state inside
    {S_START, S_WAIT_ADDR, S_SEND, S_WAIT_DATA};
  assign abortable = !(state inside
    {S_IDLE, S_ABT_HOLD, S_ABT_STOP, S_ABT_WAIT});

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    idx_n    = idx;
    tx_n     = tx_data;
    cnt_n    = retry_cnt;
    if (abort && abortable) begin
      // In-flight frames must be closed on the bus first.
      state_n = in_flight ? S_ABT_HOLD : S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (rise) begin
          shadow_n = payload;
          tx_n     = SLV_ADDR;
          cnt_n    = '0;
          idx_n    = '0;
          state_n  = S_START;
        end
        S_START: if (!ready) state_n = S_WAIT_ADDR;
        S_WAIT_ADDR: if (cmpl) begin
          if (bad) begin
            state_n = S_RTY_STOP;
          end else begin
            idx_n   = '0;
            tx_n    = shadow[7:0];
            state_n = S_SEND;
          end
        end
        S_SEND: if (!ready) state_n = S_WAIT_DATA;
        S_WAIT_DATA: if (cmpl) begin
          if (bad) begin
            state_n = S_RTY_STOP;
          end else if (idx == LAST_IDX) begin
            state_n = S_STOP;
          end else begin
            idx_n   = idx_inc;
            tx_n    = nxt_byte;
            state_n = S_SEND;
          end
        end
        S_RTY_STOP: if (!ready) state_n = S_RTY_WAIT;
        S_RTY_WAIT: if (ready) begin
          if (retry_cnt < 3'(MAX_RETRY)) begin
            cnt_n   = retry_cnt + 3'd1;
            tx_n    = SLV_ADDR;
            state_n = S_START;
          end else begin
            state_n = S_FAIL;
          end
        end
        S_STOP:      if (!ready) state_n = S_STOP_WAIT;
        S_STOP_WAIT: if (ready) state_n = S_DONE;
        // Let the master finish its current byte before the STOP.
        S_ABT_HOLD:  if (ready) state_n = S_ABT_STOP;
        S_ABT_STOP:  if (!ready) state_n = S_ABT_WAIT;
        S_ABT_WAIT:  if (ready) state_n = S_FAIL;
        S_DONE:      if (!send_trigger) state_n = S_IDLE;
        S_FAIL:      if (!send_trigger) state_n = S_IDLE;
        default:     state_n = S_IDLE;
      endcase
    end
  end

  assign start  = (state == S_START);
  assign stop   = state inside {S_RTY_STOP, S_STOP, S_ABT_STOP};
  assign i2c_en = start | stop | (state == S_SEND);
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign error  = (state == S_FAIL);

endmodule

// File: tb/tb_i2c_frame_sequencer.sv
// Bench for i2c_frame_sequencer: random byte-level master with scripted
// NACKs, frame-level reference model, summary line at the end.
module tb_i2c_frame_sequencer;

  localparam int NB   = 5;
  localparam int MR   = 2;
  localparam int EV_S = 256;
  localparam int EV_P = 257;
`ifdef I2C_FRAME_CHECKSUM_EN
  localparam int NBE = NB + 1;
`else
  localparam int NBE = NB;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            send_trigger;
  logic [NB*8-1:0] payload;
  logic            abort;
  logic            ready;
  logic            tx_done;
  logic            nack;
  logic            start;
  logic            stop;
  logic            i2c_en;
  logic [7:0]      tx_data;
  logic            busy;
  logic            done;
  logic            error;
  logic [2:0]      retry_cnt;

  i2c_frame_sequencer #(
    .NUM_BYTES(NB),
    .SLV_ADDR (8'hAA),
    .MAX_RETRY(MR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .send_trigger(send_trigger),
    .payload     (payload),
    .abort       (abort),
    .ready       (ready),
    .tx_done     (tx_done),
    .nack        (nack),
    .start       (start),
    .stop        (stop),
    .i2c_en      (i2c_en),
    .tx_data     (tx_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .retry_cnt   (retry_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ev_q[$];
  int exp_q[$];
  bit exp_ok;
  int exp_rc;
  int plan[8];
  int att;
  int data_cnt;
  int stop_rise_cyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Byte-level master: accepts a command, drops ready, completes later.
  initial begin : master
    bit is_stop;
    bit nk;
    int cur;
    int pos;
    ready   = 1'b1;
    tx_done = 1'b0;
    nack    = 1'b0;
    cur     = 0;
    pos     = 0;
    forever begin
      @(negedge clk);
      if (!reset && ready && i2c_en) begin
        is_stop = stop;
        nk      = 1'b0;
        if (start) begin
          ev_q.push_back(EV_S);
          ev_q.push_back(int'(tx_data));
          cur = att;
          att++;
          pos = 0;
          nk  = (cur < 8) && (plan[cur] == 0);
        end else if (stop) begin
          ev_q.push_back(EV_P);
        end else begin
          ev_q.push_back(int'(tx_data));
          pos++;
          data_cnt++;
          nk = (cur < 8) && (plan[cur] == pos);
        end
        ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        if (!is_stop) begin
          tx_done = 1'b1;
          nack    = nk;
          @(negedge clk);
          tx_done = 1'b0;
          nack    = 1'b0;
        end
        ready = 1'b1;
        if (is_stop) stop_rise_cyc = cyc;
      end
    end
  end

  // Frame-level model: one START/ADDR/bytes/STOP run per attempt.
  task automatic build_exp(input logic [NB*8-1:0] pl);
    logic [7:0] cs;
    bit nk;
    cs = 8'hAA;
    for (int k = 0; k < NB; k++) cs = cs ^ pl[8*k +: 8];
    exp_q.delete();
    exp_ok = 1'b0;
    exp_rc = MR;
    for (int a = 0; a <= MR; a++) begin
      exp_q.push_back(EV_S);
      exp_q.push_back(8'hAA);
      nk = (plan[a] == 0);
      for (int k = 0; k < NBE && !nk; k++) begin
        exp_q.push_back(k < NB ? int'(pl[8*k +: 8]) : int'(cs));
        nk = (plan[a] == k + 1);
      end
      exp_q.push_back(EV_P);
      if (!nk) begin
        exp_ok = 1'b1;
        exp_rc = a;
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [NB*8-1:0] pl,
                           input int abort_at, input bit retrig);
    bit got;
    int stage;
    ev_q.delete();
    att      = 0;
    data_cnt = 0;
    payload  = pl;
    if (abort_at >= 0) begin
      exp_q.delete();
      exp_q.push_back(EV_S);
      exp_q.push_back(8'hAA);
      for (int k = 0; k <= abort_at; k++)
        exp_q.push_back(int'(pl[8*k +: 8]));
      exp_q.push_back(EV_P);
      exp_ok = 1'b0;
      exp_rc = 0;
    end else begin
      build_exp(pl);
    end
    send_trigger = 1'b1;
    @(negedge clk);
    chk("lat_start", start, 1);
    got   = 1'b0;
    stage = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done || error) begin
        got = 1'b1;
        break;
      end
      if (abort_at >= 0) begin
        if (stage == 0 && data_cnt == abort_at + 1) begin
          abort = 1'b1;
          stage = 1;
        end else if (stage == 1) begin
          abort = 1'b0;
          stage = 2;
        end
      end
      if (retrig) begin
        if (stage == 0 && data_cnt == 1) begin
          payload      = ~pl;
          send_trigger = 1'b0;
          stage        = 1;
        end else if (stage == 1) begin
          send_trigger = 1'b1;
          stage        = 2;
        end
      end
    end
    chk("frame_end", got, 1);
    if (!got) begin
      reset = 1'b1;
      send_trigger = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      return;
    end
    if (done) chk("lat_done", cyc - stop_rise_cyc, 1);
    chk("done", done, exp_ok);
    chk("error", error, !exp_ok);
    chk("retry_cnt", retry_cnt, exp_rc);
    chk("busy_hold", busy, 1);
    chk("ev_count", ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      chk($sformatf("ev%0d", i), ev_q[i], exp_q[i]);
    send_trigger = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_stat", {done, error}, 0);
    repeat (20) @(negedge clk);
    chk("no_extra", ev_q.size(), exp_q.size());
  endtask

  task automatic clr_plan();
    for (int a = 0; a < 8; a++) plan[a] = -1;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [NB*8-1:0] pl;
    int n;
    bit hit;
    reset        = 1'b1;
    send_trigger = 1'b0;
    abort        = 1'b0;
    payload      = '0;
    att          = 0;
    data_cnt     = 0;
    clr_plan();
    repeat (3) @(negedge clk);
    chk("reset_out",
        {start, stop, i2c_en, busy, done, error, retry_cnt, tx_data}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // ACK everywhere
    run_frame(40'h01_23_45_67_89, -1, 1'b0);

    // NACK on the first address only
    clr_plan();
    plan[0] = 0;
    run_frame(40'h01_23_45_67_89, -1, 1'b0);

    // NACK on every address
    for (int a = 0; a < 8; a++) plan[a] = 0;
    run_frame(40'hDE_AD_BE_EF_5A, -1, 1'b0);

    // abort during data byte 2
    clr_plan();
    run_frame(40'h10_32_54_76_98, 2, 1'b0);

    // payload change and trigger re-pulse mid-frame
    run_frame(40'hC3_A5_5A_3C_F0, -1, 1'b1);

    // reset mid-frame: no STOP follows
    ev_q.delete();
    att          = 0;
    data_cnt     = 0;
    payload      = 40'h11_22_33_44_55;
    send_trigger = 1'b1;
    hit          = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (data_cnt == 2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rst_reach", hit, 1);
    n     = ev_q.size();
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cmd", {start, stop, i2c_en}, 0);
    send_trigger = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_nostop", ev_q.size(), n);
    chk("rst_idle", busy, 0);

    // random payloads and NACK plans
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < NB; k++) pl[8*k +: 8] = 8'($urandom());
      for (int a = 0; a < 8; a++)
        plan[a] = ($urandom_range(0, 2) == 0) ?
                  int'($urandom_range(0, NBE)) : -1;
      run_frame(pl, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
